// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Holds the pipeline entry layout and the word-alignment helper.
package if_pkg;

    localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;
    localparam logic [31:0] PC_STEP      = 32'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        vld;
    } if_entry_t;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_skid_buf.sv
// One-entry skid register: captures a fetch response while decode is stalled
// and hands it back once the stall lifts. Clear has priority over capture.
module if_skid_buf
    import if_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        capture_i,
    input  logic        drain_i,
    input  logic        clear_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] inst_i,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        vld_o
);

    if_entry_t entry_q;
    if_entry_t entry_d;

    // Next-state: clear, then capture into an empty slot, then drain, else hold
    always_comb begin
        entry_d = entry_q;
        if (clear_i) begin
            entry_d.vld = 1'b0;
        end else if (capture_i && !entry_q.vld) begin
            entry_d.pc   = pc_i;
            entry_d.inst = inst_i;
            entry_d.vld  = 1'b1;
        end else if (drain_i) begin
            entry_d.vld = 1'b0;
        end else begin
            entry_d = entry_q;
        end
    end

    // Entry register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            entry_q <= '{pc: 32'h0000_0000, inst: 32'h0000_0000, vld: 1'b0};
        end else begin
            entry_q <= entry_d;
        end
    end

    assign pc_o   = entry_q.pc;
    assign inst_o = entry_q.inst;
    assign vld_o  = entry_q.vld;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch and IF/ID register: owns the PC, talks to a 1-cycle
// synchronous instruction memory, and absorbs stalls and redirects.
module if_fetch_stage
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        ID_stall,
    input  logic        EX_flush,
    input  logic [31:0] EX_br_target,
    output logic [31:0] imem_addr,
    output logic        imem_rden,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ID_pc,
    output logic [31:0] ID_inst,
    output logic        ID_insn_vld
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic        req_vld_q, req_vld_d;
    if_entry_t   id_q, id_d;

    logic        issue_s;
    logic [31:0] fetch_addr_s;
    logic [31:0] skid_pc_s, skid_inst_s;
    logic        skid_vld_s;
    logic        skid_cap_s, skid_drn_s;

    // Request issue: a redirect always fetches, even while decode is stalled
    always_comb begin
        issue_s = EX_flush | ~ID_stall;
        if (EX_flush) begin
            fetch_addr_s = align_word(EX_br_target);
        end else begin
            fetch_addr_s = pc_q;
        end
    end

    assign imem_addr  = fetch_addr_s;
    assign imem_rden  = issue_s;
    assign skid_cap_s = ID_stall & req_vld_q;
    assign skid_drn_s = ~ID_stall & skid_vld_s;

    if_skid_buf u_skid (
        .clk_i     (i_clk),
        .rst_i     (i_rst),
        .capture_i (skid_cap_s),
        .drain_i   (skid_drn_s),
        .clear_i   (EX_flush),
        .pc_i      (req_pc_q),
        .inst_i    (imem_rdata),
        .pc_o      (skid_pc_s),
        .inst_o    (skid_inst_s),
        .vld_o     (skid_vld_s)
    );

    // PC and in-flight request tracking
    always_comb begin
        pc_d      = pc_q;
        req_pc_d  = req_pc_q;
        req_vld_d = 1'b0;
        if (issue_s) begin
            pc_d      = fetch_addr_s + PC_STEP;
            req_pc_d  = fetch_addr_s;
            req_vld_d = 1'b1;
        end else begin
            pc_d      = pc_q;
            req_vld_d = 1'b0;
        end
    end

    // IF/ID next state: flush beats stall; the skid entry is older than the live response
    always_comb begin
        id_d = id_q;
        if (EX_flush) begin
            id_d = '{pc: 32'h0000_0000, inst: NOP_INST, vld: 1'b0};
        end else if (ID_stall) begin
            id_d = id_q;
        end else if (skid_vld_s) begin
            id_d = '{pc: skid_pc_s, inst: skid_inst_s, vld: 1'b1};
        end else if (req_vld_q) begin
            id_d = '{pc: req_pc_q, inst: imem_rdata, vld: 1'b1};
        end else begin
            id_d.inst = NOP_INST;
            id_d.vld  = 1'b0;
        end
    end

    // State registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pc_q      <= RESET_PC;
            req_pc_q  <= 32'h0000_0000;
            req_vld_q <= 1'b0;
            id_q      <= '{pc: 32'h0000_0000, inst: NOP_INST, vld: 1'b0};
        end else begin
            pc_q      <= pc_d;
            req_pc_q  <= req_pc_d;
            req_vld_q <= req_vld_d;
            id_q      <= id_d;
        end
    end

    assign ID_pc       = id_q.pc;
    assign ID_inst     = id_q.inst;
    assign ID_insn_vld = id_q.vld;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: a memory whose word equals its address,
// with expected IF/ID contents queued per step and compared after each edge.
module tb_if_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        ID_stall;
    logic        EX_flush;
    logic [31:0] EX_br_target;
    logic [31:0] imem_addr;
    logic        imem_rden;
    logic [31:0] imem_rdata = 32'h0000_0000;
    logic [31:0] ID_pc;
    logic [31:0] ID_inst;
    logic        ID_insn_vld;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        vld;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    if_fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INST(32'h0000_0013)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .ID_stall     (ID_stall),
        .EX_flush     (EX_flush),
        .EX_br_target (EX_br_target),
        .imem_addr    (imem_addr),
        .imem_rden    (imem_rden),
        .imem_rdata   (imem_rdata),
        .ID_pc        (ID_pc),
        .ID_inst      (ID_inst),
        .ID_insn_vld  (ID_insn_vld)
    );

    always #5 i_clk = ~i_clk;

    // Synchronous-read instruction memory, word = address
    always @(posedge i_clk) begin
        if (imem_rden) imem_rdata <= imem_addr;
    end

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One cycle: drive at negedge, check fetch outputs, clock, check IF/ID
    task automatic cyc(input logic stall, input logic flush, input logic [31:0] tgt,
                       input logic [31:0] exp_addr, input logic exp_rden,
                       input logic [31:0] id_pc, input logic [31:0] id_inst, input logic id_vld);
        exp_t e;
        ID_stall     = stall;
        EX_flush     = flush;
        EX_br_target = tgt;
        e = {id_pc, id_inst, id_vld};
        sb_q.push_back(e);
        #1;
        check32("imem_addr", imem_addr, exp_addr);
        check32("imem_rden", {31'd0, imem_rden}, {31'd0, exp_rden});
        @(posedge i_clk);
        #1;
        e = sb_q.pop_front();
        check32("ID_pc", ID_pc, e.pc);
        check32("ID_inst", ID_inst, e.inst);
        check32("ID_insn_vld", {31'd0, ID_insn_vld}, {31'd0, e.vld});
        check32("skid_req_excl",
                {31'd0, (~ID_stall & dut.skid_vld_s & dut.req_vld_q)}, 32'd0);
        @(negedge i_clk);
    endtask

    initial begin
        i_rst = 1'b1; ID_stall = 1'b0; EX_flush = 1'b0; EX_br_target = 32'h0;
        #12;
        check32("rst_vld", {31'd0, ID_insn_vld}, 32'd0);
        check32("rst_inst", ID_inst, NOP);
        check32("rst_pc", ID_pc, 32'h0);
        check32("rst_addr", imem_addr, 32'h0);
        @(negedge i_clk);
        i_rst = 1'b0;

        // Free run: first valid ID on the 2nd edge
        cyc(1'b0, 1'b0, 32'h0, 32'h0000_0000, 1'b1, 32'h0000_0000, NOP,          1'b0);
        cyc(1'b0, 1'b0, 32'h0, 32'h0000_0004, 1'b1, 32'h0000_0000, 32'h0000_0000, 1'b1);
        cyc(1'b0, 1'b0, 32'h0, 32'h0000_0008, 1'b1, 32'h0000_0004, 32'h0000_0004, 1'b1);
        cyc(1'b0, 1'b0, 32'h0, 32'h0000_000C, 1'b1, 32'h0000_0008, 32'h0000_0008, 1'b1);
        // One-cycle stall while ID holds 0x8
        cyc(1'b1, 1'b0, 32'h0, 32'h0000_0010, 1'b0, 32'h0000_0008, 32'h0000_0008, 1'b1);
        cyc(1'b0, 1'b0, 32'h0, 32'h0000_0010, 1'b1, 32'h0000_000C, 32'h0000_000C, 1'b1);
        cyc(1'b0, 1'b0, 32'h0, 32'h0000_0014, 1'b1, 32'h0000_0010, 32'h0000_0010, 1'b1);
        // Three-cycle stall: 0x14 parked in skid, no requests
        cyc(1'b1, 1'b0, 32'h0, 32'h0000_0018, 1'b0, 32'h0000_0010, 32'h0000_0010, 1'b1);
        cyc(1'b1, 1'b0, 32'h0, 32'h0000_0018, 1'b0, 32'h0000_0010, 32'h0000_0010, 1'b1);
        cyc(1'b1, 1'b0, 32'h0, 32'h0000_0018, 1'b0, 32'h0000_0010, 32'h0000_0010, 1'b1);
        cyc(1'b0, 1'b0, 32'h0, 32'h0000_0018, 1'b1, 32'h0000_0014, 32'h0000_0014, 1'b1);
        cyc(1'b0, 1'b0, 32'h0, 32'h0000_001C, 1'b1, 32'h0000_0018, 32'h0000_0018, 1'b1);
        // Flush to 0x100 with 0x1C in flight
        cyc(1'b0, 1'b1, 32'h0000_0100, 32'h0000_0100, 1'b1, 32'h0000_0000, NOP, 1'b0);
        cyc(1'b0, 1'b0, 32'h0, 32'h0000_0104, 1'b1, 32'h0000_0100, 32'h0000_0100, 1'b1);
        cyc(1'b0, 1'b0, 32'h0, 32'h0000_0108, 1'b1, 32'h0000_0104, 32'h0000_0104, 1'b1);
        // Fill skid, then flush+stall to unaligned 0x202
        cyc(1'b1, 1'b0, 32'h0, 32'h0000_010C, 1'b0, 32'h0000_0104, 32'h0000_0104, 1'b1);
        cyc(1'b1, 1'b1, 32'h0000_0202, 32'h0000_0200, 1'b1, 32'h0000_0000, NOP, 1'b0);
        cyc(1'b0, 1'b0, 32'h0, 32'h0000_0204, 1'b1, 32'h0000_0200, 32'h0000_0200, 1'b1);
        cyc(1'b0, 1'b0, 32'h0, 32'h0000_0208, 1'b1, 32'h0000_0204, 32'h0000_0204, 1'b1);
        // PC wrap at the top of the address space
        cyc(1'b0, 1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFF8, 1'b1, 32'h0000_0000, NOP, 1'b0);
        cyc(1'b0, 1'b0, 32'h0, 32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFF8, 1'b1);
        cyc(1'b0, 1'b0, 32'h0, 32'h0000_0000, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b1);
        cyc(1'b0, 1'b0, 32'h0, 32'h0000_0004, 1'b1, 32'h0000_0000, 32'h0000_0000, 1'b1);

        // Asynchronous reset mid-stream
        #2 i_rst = 1'b1;
        #1;
        check32("arst_vld", {31'd0, ID_insn_vld}, 32'd0);
        check32("arst_inst", ID_inst, NOP);
        check32("arst_pc", ID_pc, 32'h0);
        check32("arst_addr", imem_addr, 32'h0);
        @(negedge i_clk);
        check32("arst_hold_addr", imem_addr, 32'h0);
        i_rst = 1'b0;
        cyc(1'b0, 1'b0, 32'h0, 32'h0000_0000, 1'b1, 32'h0000_0000, NOP,          1'b0);
        cyc(1'b0, 1'b0, 32'h0, 32'h0000_0004, 1'b1, 32'h0000_0000, 32'h0000_0000, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
